// File: rtl/video_mode_ctrl.sv
// video_mode_ctrl: run-time HDMI video-mode sequencer driving DCM_CLKGEN M/D/GO and timing-generator compares.
// Latency: LOAD -> GO in 2 cycles (plus dcm_busy wait); ready follows LOCK_HOLD cycles of stable synchronised PLL lock.
// Backpressure: GO is held off while dcm_busy=1; mode requests are accepted every cycle, the last request wins.
module video_mode_ctrl #(
    parameter logic [1:0]  DEFAULT_MODE = 2'd0,
    parameter logic [23:0] TIMEOUT_CYC  = 24'd1048576,
    parameter logic [15:0] LOCK_HOLD    = 16'd256,
    parameter logic [1:0]  MAX_RETRY    = 2'd3,
    parameter logic [7:0]  SETTLE_CYC   = 8'd16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  mode_sel,
    input  logic        mode_req,
    input  logic        dcm_busy,
    input  logic        progdone,
    input  logic        dfs_lckd,
    input  logic        pll_lckd_async,
    output logic [7:0]  dcm_m,
    output logic [7:0]  dcm_d,
    output logic        dcm_go,
    output logic        video_rst,
    output logic [11:0] tc_hsblnk,
    output logic [11:0] tc_hssync,
    output logic [11:0] tc_hesync,
    output logic [11:0] tc_heblnk,
    output logic [11:0] tc_vsblnk,
    output logic [11:0] tc_vssync,
    output logic [11:0] tc_vesync,
    output logic [11:0] tc_veblnk,
    output logic        hvsync_polarity,
    output logic [1:0]  mode_cur,
    output logic        ready,
    output logic        error
);

    typedef struct packed {
        logic [7:0]  m;
        logic [7:0]  d;
        logic [11:0] hsblnk;
        logic [11:0] hssync;
        logic [11:0] hesync;
        logic [11:0] heblnk;
        logic [11:0] vsblnk;
        logic [11:0] vssync;
        logic [11:0] vesync;
        logic [11:0] veblnk;
        logic        pol;
    } cfg_t;

    typedef enum logic [3:0] {
        S_LOAD,
        S_WAIT_IDLE,
        S_GO,
        S_SETTLE,
        S_WAIT_DCM,
        S_WAIT_PLL,
        S_RUN,
        S_RETRY,
        S_FAIL
    } state_t;

    // M and D are stored as value-1, the form dcmspi expects.
    function automatic cfg_t mode_cfg(input logic [1:0] mode);
        cfg_t c;
        case (mode)
            2'd0:    c = '{8'd198, 8'd66,  12'd1919, 12'd2007, 12'd2051, 12'd2199,
                           12'd1079, 12'd1083, 12'd1088, 12'd1124, 1'b0};
            2'd1:    c = '{8'd198, 8'd133, 12'd1279, 12'd1389, 12'd1429, 12'd1649,
                           12'd719,  12'd724,  12'd729,  12'd749,  1'b0};
            2'd2:    c = '{8'd1,   8'd3,   12'd639,  12'd655,  12'd751,  12'd799,
                           12'd479,  12'd489,  12'd491,  12'd524,  1'b1};
            default: c = '{8'd12,  8'd9,   12'd1023, 12'd1047, 12'd1183, 12'd1343,
                           12'd767,  12'd770,  12'd776,  12'd805,  1'b1};
        endcase
        return c;
    endfunction

    state_t      state_q, state_d;
    logic [1:0]  mode_q, mode_d;
    cfg_t        cfg_q, cfg_d;
    logic        pend_vld_q, pend_vld_d;
    logic [1:0]  pend_mode_q, pend_mode_d;
    logic [1:0]  retry_q, retry_d;
    logic        err_q, err_d;
    logic [7:0]  settle_q, settle_d;
    logic [23:0] tmo_q, tmo_d;
    logic [15:0] hold_q, hold_d;
    logic        pll_meta_q, pll_meta_d;
    logic        pll_sync_q, pll_sync_d;

    // State, configuration and counter registers; reset restarts from LOAD with the default mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_LOAD;
            mode_q      <= DEFAULT_MODE;
            cfg_q       <= mode_cfg(DEFAULT_MODE);
            pend_vld_q  <= 1'b0;
            pend_mode_q <= 2'd0;
            retry_q     <= 2'd0;
            err_q       <= 1'b0;
            settle_q    <= 8'd0;
            tmo_q       <= 24'd0;
            hold_q      <= 16'd0;
            pll_meta_q  <= 1'b0;
            pll_sync_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            cfg_q       <= cfg_d;
            pend_vld_q  <= pend_vld_d;
            pend_mode_q <= pend_mode_d;
            retry_q     <= retry_d;
            err_q       <= err_d;
            settle_q    <= settle_d;
            tmo_q       <= tmo_d;
            hold_q      <= hold_d;
            pll_meta_q  <= pll_meta_d;
            pll_sync_q  <= pll_sync_d;
        end
    end

    // Next-state, request capture and counter logic.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        cfg_d       = cfg_q;
        pend_vld_d  = pend_vld_q;
        pend_mode_d = pend_mode_q;
        retry_d     = retry_q;
        err_d       = err_q;
        settle_d    = 8'd0;
        hold_d      = 16'd0;
        pll_meta_d  = pll_lckd_async;
        pll_sync_d  = pll_meta_q;
        // Free-running saturating timeout; GO clears it so WAIT_DCM measures from GO.
        tmo_d       = (tmo_q == 24'hFF_FFFF) ? tmo_q : tmo_q + 24'd1;

        // Outside RUN and FAIL a request is parked until the current mode is up.
        if (mode_req && state_q != S_RUN && state_q != S_FAIL) begin
            pend_vld_d  = 1'b1;
            pend_mode_d = mode_sel;
        end

        case (state_q)
            S_LOAD: begin
                cfg_d   = mode_cfg(mode_q);
                state_d = S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
                if (!dcm_busy) state_d = S_GO;
            end
            S_GO: begin
                tmo_d   = 24'd0;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                settle_d = settle_q + 8'd1;
                if (settle_d >= SETTLE_CYC) state_d = S_WAIT_DCM;
            end
            S_WAIT_DCM: begin
                if (progdone && dfs_lckd)      state_d = S_WAIT_PLL;
                else if (tmo_q >= TIMEOUT_CYC) state_d = S_RETRY;
            end
            S_WAIT_PLL: begin
                if (pll_sync_q) hold_d = (hold_q == 16'hFFFF) ? hold_q : hold_q + 16'd1;
                if (hold_q >= LOCK_HOLD) begin
                    state_d = S_RUN;
                    retry_d = 2'd0;
                end
            end
            S_RUN: begin
                pend_vld_d = 1'b0;
                // A live request overrides anything parked; one equal to the current mode is a no-op.
                if (mode_req) begin
                    if (mode_sel != mode_q) begin
                        mode_d  = mode_sel;
                        state_d = S_LOAD;
                    end
                end else if (pend_vld_q && pend_mode_q != mode_q) begin
                    mode_d  = pend_mode_q;
                    state_d = S_LOAD;
                end
                // Losing either lock reprograms the same mode without consuming a retry.
                if (state_d == S_RUN && (!dfs_lckd || !pll_sync_q)) state_d = S_LOAD;
            end
            S_RETRY: begin
                if (retry_q < MAX_RETRY) begin
                    retry_d = retry_q + 2'd1;
                    state_d = S_LOAD;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_FAIL;
                end
            end
            S_FAIL: begin
                if (mode_req) begin
                    err_d      = 1'b0;
                    retry_d    = 2'd0;
                    mode_d     = mode_sel;
                    pend_vld_d = 1'b0;
                    state_d    = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    assign dcm_go          = (state_q == S_GO);
    assign ready           = (state_q == S_RUN);
    assign video_rst       = (state_q != S_RUN);
    assign error           = err_q;
    assign mode_cur        = mode_q;
    assign dcm_m           = cfg_q.m;
    assign dcm_d           = cfg_q.d;
    assign tc_hsblnk       = cfg_q.hsblnk;
    assign tc_hssync       = cfg_q.hssync;
    assign tc_hesync       = cfg_q.hesync;
    assign tc_heblnk       = cfg_q.heblnk;
    assign tc_vsblnk       = cfg_q.vsblnk;
    assign tc_vssync       = cfg_q.vssync;
    assign tc_vesync       = cfg_q.vesync;
    assign tc_veblnk       = cfg_q.veblnk;
    assign hvsync_polarity = cfg_q.pol;

endmodule

// File: doc/video_mode_ctrl.md
Name: video_mode_ctrl

Overview:
- Run-time video-mode sequencer for the HDMI transmit path.
- Selects one of four display modes and drives the M/D values and GO pulse of the dcmspi/DCM_CLKGEN pixel-clock generator.
- Waits for DCM lock and then stable PLL lock, and supplies the matching timing-generator compare values and sync polarity.
- Holds the video datapath (timing, colorbar, encoder) in reset until the new clock is clean.
- Runs in the 50 MHz PROGCLK domain.

Parameters:
- DEFAULT_MODE, 2'd0: mode programmed after reset.
- TIMEOUT_CYC, 24'd1048576: maximum cycles to wait for DCM lock after GO.
- LOCK_HOLD, 16'd256: cycles the synchronised PLL lock must stay high before the datapath is released.
- MAX_RETRY, 2'd3: reprogram attempts before a sticky error.
- SETTLE_CYC, 8'd16: cycles after GO during which progdone/dfs_lckd are ignored.

Ports:
- clk  in  1  PROGCLK domain clock (50 MHz BUFG).
- rst  in  1  synchronous, active-high reset.
- mode_sel  in  2  requested mode: 0=1080p60, 1=720p60, 2=640x480p60, 3=1024x768p60.
- mode_req  in  1  one-cycle request strobe; samples mode_sel.
- dcm_busy  in  1  dcmspi BUSY.
- progdone  in  1  DCM_CLKGEN PROGDONE.
- dfs_lckd  in  1  DCM_CLKGEN LOCKED.
- pll_lckd_async  in  1  PLL_BASE LOCKED; asynchronous, synchronised internally with 2 flops.
- dcm_m  out  8  M-1 to dcmspi.
- dcm_d  out  8  D-1 to dcmspi.
- dcm_go  out  1  one-cycle GO pulse to dcmspi.
- video_rst  out  1  datapath hold-off reset, active high.
- tc_hsblnk, tc_hssync, tc_hesync, tc_heblnk  out  12 each  horizontal compare values.
- tc_vsblnk, tc_vssync, tc_vesync, tc_veblnk  out  12 each  vertical compare values.
- hvsync_polarity  out  1  1 = negative syncs.
- mode_cur  out  2  mode currently programmed or being programmed.
- ready  out  1  high only in RUN.
- error  out  1  sticky retry-exhausted flag.

Behaviour:
Mode table (M,D are the true values; outputs carry value-1; the four H values, then the four V values, then polarity):
- 0: M=199, D=67; H 1919/2007/2051/2199; V 1079/1083/1088/1124; pol 0.
- 1: M=199, D=134; H 1279/1389/1429/1649; V 719/724/729/749; pol 0.
- 2: M=2, D=4; H 639/655/751/799; V 479/489/491/524; pol 1.
- 3: M=13, D=10; H 1023/1047/1183/1343; V 767/770/776/805; pol 1.

Reset values:
- FSM goes to LOAD with mode_cur=DEFAULT_MODE.
- dcm_go=0, video_rst=1, ready=0, error=0, retry count=0, pending flag=0.
- dcm_m, dcm_d, tc_* and polarity hold the DEFAULT_MODE entries.

FSM:
- LOAD: register the mode_cur table entry into all config outputs (1 cycle) -> WAIT_IDLE.
- WAIT_IDLE: when dcm_busy=0 -> GO.
- GO: dcm_go=1 for exactly one cycle; clear the timeout counter -> SETTLE.
- SETTLE: count SETTLE_CYC cycles -> WAIT_DCM.
- WAIT_DCM: when progdone=1 and dfs_lckd=1 -> WAIT_PLL. If the timeout counter (counting from GO) reaches TIMEOUT_CYC -> RETRY.
- WAIT_PLL: hold counter increments while the synchronised lock is 1 and clears to 0 whenever it drops. At LOCK_HOLD -> RUN.
- RUN: video_rst=0, ready=1.
  - Drop of dfs_lckd or the synchronised PLL lock -> video_rst=1 in the next cycle, then LOAD with the same mode (does not count as a retry).
- RETRY:
  - If retry count < MAX_RETRY: increment it, -> LOAD.
  - Otherwise: error=1 -> FAIL.
- FAIL: terminal; video_rst=1. Only rst or a new mode_req leaves it; mode_req clears error and the retry count, then -> LOAD.

Mode requests and counters:
- Requests are accepted in every state.
  - In RUN: mode_sel is captured into mode_cur -> LOAD next cycle. A request equal to mode_cur is ignored.
  - In any other state except FAIL: mode_sel is stored as pending. On entering RUN, a pending request that differs from mode_cur is applied immediately (RUN lasts 1 cycle, ready pulses).
  - The last request wins.
- The retry count clears on entering RUN.
- video_rst is 1 in every state other than RUN and asserts in the same cycle the FSM leaves RUN.
- dcm_m, dcm_d and tc_* change only in LOAD, and therefore only while video_rst=1.
- The timeout counter saturates and never wraps.
- rst mid-sequence aborts immediately and restarts from LOAD with DEFAULT_MODE. An in-flight dcmspi transaction is tolerated because WAIT_IDLE waits for dcm_busy=0.

Test Plan:
1. Reset with DEFAULT_MODE=0, dcm_busy=0; model progdone/dfs_lckd high 100 cycles after GO and PLL lock 50 cycles later. Required:
   - exactly one dcm_go pulse with dcm_m=198, dcm_d=66;
   - ready rises LOCK_HOLD+2 cycles after the synchronised lock;
   - tc_heblnk=2199, tc_veblnk=1124.
2. In RUN, mode_req with mode_sel=2. Required:
   - video_rst=1 the next cycle;
   - dcm_m=1, dcm_d=3, tc_hsblnk=639, hvsync_polarity=1;
   - a new GO pulse; ready returns after relock.
3. Never assert dfs_lckd after GO. Required:
   - 4 GO pulses spaced TIMEOUT_CYC (override to 1000) apart;
   - then error=1, video_rst=1, no further GO pulses;
   - a subsequent mode_req clears error and produces a new GO.
4. PLL lock glitches low once in WAIT_PLL. Required: the hold counter restarts and ready is delayed by a full LOCK_HOLD.
5. mode_req with mode_sel=3, then mode_sel=1, during WAIT_DCM of mode 0. Required:
   - mode 0 completes;
   - ready is a 1-cycle pulse;
   - mode 1 is then programmed (dcm_d=133).
6. Assert rst during SETTLE. Required:
   - video_rst stays 1, ready stays 0;
   - sequence restarts at LOAD with DEFAULT_MODE;
   - dcm_busy=1 delays GO until it falls.
